// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcode and control-state encodings.
package alu_pkg;

    localparam int ALU_SEL_W = 3;

    typedef enum logic [ALU_SEL_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL_BUSY,
        DONE
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH steps.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic               active;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CW'(WIDTH);
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
        end else if (active) begin
            if (cnt != '0) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    // done is asserted for the single cycle after the last step, while active drops.
    assign busy    = active;
    assign done    = active && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags and a multi-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     result_hi,
    output logic                 carry,
    output logic                 zero,
    output logic                 negative,
    output logic                 overflow
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state;
    alu_op_e            op;
    logic               accept;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] shl_w;
    logic [WIDTH-1:0]   r_n;
    logic               c_n;
    logic               v_n;

    assign op        = alu_op_e'(alu_sel);
    assign in_ready  = (state == IDLE && !mul_busy) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && op == OP_MUL),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        r_n   = '0;
        c_n   = 1'b0;
        v_n   = 1'b0;
        sum   = {1'b0, a} + {1'b0, b};
        diff  = a - b;
        // Bit WIDTH of the widened shift is the last bit pushed out of a.
        shl_w = {{WIDTH{1'b0}}, a} << b[SHW-1:0];
        case (op)
            OP_ADD: begin
                r_n = sum[WIDTH-1:0];
                c_n = sum[WIDTH];
                v_n = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r_n = diff;
                c_n = (a < b);
                v_n = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r_n = a & b;
            OP_OR:  r_n = a | b;
            OP_NOT: r_n = ~a;
            OP_XOR: r_n = a ^ b;
            OP_SHL: begin
                r_n = shl_w[WIDTH-1:0];
                c_n = shl_w[WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state <= MUL_BUSY;
                        end else begin
                            state     <= DONE;
                            result    <= r_n;
                            result_hi <= '0;
                            carry     <= c_n;
                            zero      <= (r_n == '0);
                            negative  <= r_n[WIDTH-1];
                            overflow  <= v_n;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        state     <= DONE;
                        result    <= mul_prod[WIDTH-1:0];
                        result_hi <= mul_prod[2*WIDTH-1:WIDTH];
                        carry     <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                        zero      <= (mul_prod == '0);
                        negative  <= mul_prod[2*WIDTH-1];
                        overflow  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table through a scoreboard, plus timing corner cases.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, result, result_hi;
    logic [2:0] alu_sel;
    logic       carry, zero, negative, overflow;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [15:0] a_w, b_w, result_w, result_hi_w;
    logic [2:0]  alu_sel_w;
    logic        carry_w, zero_w, negative_w, overflow_w;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
        .negative(negative), .overflow(overflow)
    );

    alu_seq #(.WIDTH(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .alu_sel(alu_sel_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .result(result_w), .result_hi(result_hi_w), .carry(carry_w), .zero(zero_w),
        .negative(negative_w), .overflow(overflow_w)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] hi;
        logic       c, z, n, v;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a, b;
        exp_t       e;
    } vec_t;

    exp_t q[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t mon_got, mon_exp;
    vec_t tbl[15];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = {result, result_hi, carry, zero, negative, overflow};
            pop_cyc.push_back(cyc);
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL out_unexpected got=%h exp=none", mon_got);
            end else begin
                mon_exp = q.pop_front();
                if (mon_got !== mon_exp) begin
                    mismatched++;
                    $display("FAIL out_data got=%h exp=%h (r,hi,c,z,n,v)", mon_got, mon_exp);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [2:0] s, input logic [7:0] xa, xb,
                                input logic [7:0] r, hi, input logic c, z, n, v);
        vec_t t;
        t.sel = s; t.a = xa; t.b = xb;
        t.e = {r, hi, c, z, n, v};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] s, input logic [7:0] xa, xb, input exp_t e);
        bit ok = 1'b0;
        in_valid = 1'b1; alu_sel = s; a = xa; b = xb;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0; a = 8'h00; b = 8'h00; alu_sel = 3'b000;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("drain_left", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc;
        bit   bad;
        exp_t hold;

        rst = 1'b1; out_ready = 1'b1; idle();
        in_valid_w = 1'b0; a_w = '0; b_w = '0; alu_sel_w = 3'b000; out_ready_w = 1'b1;

        tbl[0]  = mk(3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0);
        tbl[1]  = mk(3'b000, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 1);
        tbl[2]  = mk(3'b001, 8'h02, 8'h0A, 8'hF8, 8'h00, 1, 0, 1, 0);
        tbl[3]  = mk(3'b010, 8'hFF, 8'h0F, 8'h0F, 8'h00, 0, 0, 0, 0);
        tbl[4]  = mk(3'b101, 8'hF0, 8'hFF, 8'h0F, 8'h00, 0, 0, 0, 0);
        tbl[5]  = mk(3'b100, 8'hAA, 8'h00, 8'h55, 8'h00, 0, 0, 0, 0);
        tbl[6]  = mk(3'b110, 8'h81, 8'h01, 8'h02, 8'h00, 1, 0, 0, 0);
        tbl[7]  = mk(3'b110, 8'h5A, 8'h08, 8'h5A, 8'h00, 0, 0, 0, 0);
        tbl[8]  = mk(3'b011, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
        tbl[9]  = mk(3'b001, 8'h80, 8'h01, 8'h7F, 8'h00, 0, 0, 0, 1);
        tbl[10] = mk(3'b111, 8'h0F, 8'h0F, 8'hE1, 8'h00, 0, 0, 0, 0);
        tbl[11] = mk(3'b111, 8'h00, 8'h37, 8'h00, 8'h00, 0, 1, 0, 0);
        tbl[12] = mk(3'b110, 8'h01, 8'h07, 8'h80, 8'h00, 0, 0, 1, 0);
        tbl[13] = mk(3'b111, 8'h80, 8'h02, 8'h00, 8'h01, 1, 0, 0, 0);
        tbl[14] = mk(3'b001, 8'h05, 8'h05, 8'h00, 8'h00, 0, 1, 0, 0);

        #22 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {out_valid, in_ready, result, result_hi, carry, zero, negative, overflow},
            {1'b0, 1'b1, 20'h0});
        @(posedge clk); #1;

        foreach (tbl[i]) send(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].e);
        idle();
        drain();

        // Multiply latency and in_ready low while busy
        send(3'b111, 8'hFF, 8'hFF, {8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0});
        acc = cyc; idle(); bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) bad = 1'b1;
        end
        chk("mul_latency", 64'(cyc - acc), 64'd9);
        chk("mul_busy_in_ready", 64'(bad), 64'd0);
        drain();

        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        hold = {8'h44, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        send(3'b000, 8'h33, 8'h11, hold);
        idle();
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {out_valid, in_ready, result, result_hi, carry, zero, negative, overflow},
                {1'b1, 1'b0, hold});
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'b011, 8'hF0, 8'h0F, {8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        idle();
        @(negedge clk);
        chk("bp_release", {out_valid, result}, {1'b1, 8'hFF});
        @(posedge clk); #1;
        drain();

        // Throughput: back-to-back adds, one result per cycle
        pop_cyc.delete();
        send(3'b000, 8'h10, 8'h01, {8'h11, 8'h00, 4'b0000});
        send(3'b000, 8'h20, 8'h02, {8'h22, 8'h00, 4'b0000});
        send(3'b000, 8'h30, 8'h03, {8'h33, 8'h00, 4'b0000});
        send(3'b000, 8'h40, 8'h04, {8'h44, 8'h00, 4'b0000});
        idle();
        drain();
        chk("tp_count", 64'(pop_cyc.size()), 64'd4);
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
            chk("tp_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

        // Reset while multiplying
        send(3'b111, 8'h12, 8'h34, {8'hA8, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0});
        idle();
        repeat (3) @(negedge clk);
        chk("rst_busy_in_ready", 64'(in_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_out", {out_valid, result, result_hi}, 17'h0);
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        send(3'b000, 8'h01, 8'h09, {8'h0A, 8'h00, 4'b0000});
        idle();
        drain();

        // WIDTH=16 instance
        in_valid_w = 1'b1; a_w = 16'hFFFF; b_w = 16'h0001; alu_sel_w = 3'b000;
        @(negedge clk);
        chk("w16_in_ready", 64'(in_ready_w), 64'd1);
        @(posedge clk); #1 in_valid_w = 1'b0;
        @(negedge clk);
        chk("w16_add", {out_valid_w, result_w, result_hi_w, carry_w, zero_w}, {1'b1, 32'h0, 1'b1, 1'b1});
        @(posedge clk); #1;
        in_valid_w = 1'b1; a_w = 16'h1234; b_w = 16'h0010; alu_sel_w = 3'b111;
        @(posedge clk); #1;
        acc = cyc; in_valid_w = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid_w) break;
        end
        chk("w16_mul_latency", 64'(cyc - acc), 64'd17);
        chk("w16_mul", {result_hi_w, result_w, carry_w, zero_w}, {16'h0001, 16'h2340, 1'b1, 1'b0});
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Keeps the same 3-bit opcode space and adds XOR, variable left shift and a multi-cycle unsigned multiply.
- Adds a status-flag set and valid/ready handshakes on both input and output.
- Sits between an operand-issue stage and a result consumer in datapath test harnesses; latency is fixed per opcode.

Parameters:
- WIDTH, 8, operand/result width in bits; power of two, minimum 4.
- SHW, $clog2(WIDTH), derived (localparam); shift-amount bits taken from b.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_sel  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT(a), 101 XOR, 110 SHL, 111 MUL.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result; low half of product for MUL.
- result_hi  out  WIDTH  high half of product for MUL; 0 for all other ops.
- carry  out  1  carry / borrow / shift-out / product-overflow flag.
- zero  out  1  result is zero.
- negative  out  1  MSB of the result.
- overflow  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0; result, result_hi and all flags 0; in_ready=1 after release.
- FSM states:
  - IDLE: waiting for operands.
  - MUL_BUSY: multiply in progress.
  - DONE: result held until consumed.
- Handshakes:
  - in_ready = (IDLE) or (DONE and out_ready).
  - Accept = in_valid and in_ready.
  - Output handshake = out_valid and out_ready.
- Transitions:
  - Accept of a non-MUL op: result and flags registered; DONE next cycle. Latency 1 cycle.
  - Accept of MUL: a and b latched, counter loaded WIDTH; go to MUL_BUSY. Shift-add, one bit per cycle.
  - MUL_BUSY: counter reaches 0 → DONE. out_valid rises WIDTH+1 cycles after accept.
  - DONE with out_ready=1 and a new accept: new op processed exactly as from IDLE, giving back-to-back throughput of 1 per cycle for non-MUL ops.
  - DONE with out_ready=1 and no accept: back to IDLE; out_valid=0 next cycle.
  - DONE with out_ready=0: result, result_hi and flags held stable.
- Inputs a, b and alu_sel are ignored except on an accept cycle. in_valid in MUL_BUSY is not accepted (in_ready=0).
- Arithmetic, per opcode:
  - ADD: {carry,result}=a+b.
  - SUB: result=a-b mod 2^WIDTH; carry=1 if a<b (unsigned borrow).
  - overflow (ADD/SUB only): two's-complement signed overflow.
  - AND, OR, XOR, NOT: carry=0, overflow=0.
  - SHL: shift amount = b[SHW-1:0]; result=a<<amount; carry = last bit shifted out (a[WIDTH-amount]); carry=0 when amount=0.
  - MUL: unsigned, {result_hi,result}=a*b; carry = (result_hi!=0).
- Flags:
  - zero: for MUL, all 2*WIDTH product bits are zero; otherwise result==0.
  - negative: for MUL, result_hi[WIDTH-1]; otherwise result[WIDTH-1].
  - result_hi=0 for all non-MUL ops.
- Reset mid-MUL: multiply aborted, no output produced, IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - the alu_op_e opcode enum, with 3-bit encodings as listed;
  - the alu_state_e enum (IDLE, MUL_BUSY, DONE);
  - ALU_SEL_W=3.
- One natural sub-module: alu_mul_seq.
  - Iterative shift-add multiplier with start/busy/done and a WIDTH-cycle counter.
  - Instantiated once; the top level owns the handshakes and flags.

Test Plan:
- Reset mid-stream: assert rst while MUL_BUSY → out_valid=0, result=0, in_ready=1 after release; next ADD 1+9 gives result=0x0A.
- ADD/SUB flags, WIDTH=8:
  - 0xFF+0x01 → result=0x00, carry=1, zero=1, overflow=0.
  - 0x7F+0x01 → 0x80, negative=1, overflow=1.
  - 0x02-0x0A → 0xF8, carry=1.
- Logic and shift:
  - AND 0xFF,0x0F → 0x0F.
  - XOR 0xF0,0xFF → 0x0F.
  - NOT 0xAA → 0x55.
  - SHL 0x81 by 1 → 0x02, carry=1.
  - SHL by b=0x08 (amount 0) → result=a, carry=0.
- MUL: 0xFF*0xFF → out_valid exactly 9 cycles after accept; result_hi=0xFE, result=0x01, carry=1; in_ready=0 throughout busy.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 (OR 0xF0,0x0F) → next cycle result=0xFF.
- Throughput: 4 consecutive ADDs with out_ready=1 → 4 results on 4 consecutive cycles, in order. Repeat at WIDTH=16: 0xFFFF+1 → result=0, carry=1.
